// File: rtl/traffic_sensor_conditioner.sv
// Conditions two raw car sensors into request levels for the traffic light controller:
// two-flop synchroniser, debounce counter, then an optional clear-able request latch.
module traffic_sensor_conditioner #(
   parameter int unsigned DB_CYCLES = 4,
   parameter bit          LATCH     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_a,
   input  logic raw_b,
   input  logic clr_a,
   input  logic clr_b,
   output logic sa,
   output logic sb,
   output logic stable_a,
   output logic stable_b
);

   localparam logic [7:0] CntMax = 8'(DB_CYCLES - 1);

   // Bit 0 is street A, bit 1 is street B; the channels never interact.
   logic [1:0] raw, clr;
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] stable_q, stable_d;
   logic [1:0] req_q, req_d;
   logic [7:0] cnt_q [2];
   logic [7:0] cnt_d [2];

   assign raw = {raw_b, raw_a};
   assign clr = {clr_b, clr_a};

   always_comb begin
      stable_d = stable_q;
      req_d    = req_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = 8'd0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] >= CntMax) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
         // The request follows the new debounced level so sx and stable_x change on the same edge.
         if (LATCH) begin
            req_d[i] = stable_d[i] | (req_q[i] & ~clr[i]);
         end else begin
            req_d[i] = stable_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         stable_q <= 2'b00;
         req_q    <= 2'b00;
         cnt_q[0] <= 8'd0;
         cnt_q[1] <= 8'd0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         req_q    <= req_d;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   assign sa       = req_q[0];
   assign sb       = req_q[1];
   assign stable_a = stable_q[0];
   assign stable_b = stable_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Checks three conditioner configurations (4/latched, 4/transparent, 1/latched) against a
// history-based model: a level becomes stable after DB consecutive synchronised samples.
module tb_traffic_sensor_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic raw_a = 1'b0, raw_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;

   logic sa0, sb0, sta0, stb0;
   logic sa1, sb1, sta1, stb1;
   logic sa2, sb2, sta2, stb2;

   always #5 clk = ~clk;

   traffic_sensor_conditioner #(.DB_CYCLES(4), .LATCH(1'b1)) u_dut0 (
      .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .clr_a(clr_a), .clr_b(clr_b),
      .sa(sa0), .sb(sb0), .stable_a(sta0), .stable_b(stb0));

   traffic_sensor_conditioner #(.DB_CYCLES(4), .LATCH(1'b0)) u_dut1 (
      .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .clr_a(clr_a), .clr_b(clr_b),
      .sa(sa1), .sb(sb1), .stable_a(sta1), .stable_b(stb1));

   traffic_sensor_conditioner #(.DB_CYCLES(1), .LATCH(1'b1)) u_dut2 (
      .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .clr_a(clr_a), .clr_b(clr_b),
      .sa(sa2), .sb(sb2), .stable_a(sta2), .stable_b(stb2));

   logic [1:0] got_s  [3];
   logic [1:0] got_st [3];
   assign got_s[0]  = {sb0, sa0};
   assign got_s[1]  = {sb1, sa1};
   assign got_s[2]  = {sb2, sa2};
   assign got_st[0] = {stb0, sta0};
   assign got_st[1] = {stb1, sta1};
   assign got_st[2] = {stb2, sta2};

   int unsigned m_db [3];
   bit          m_lt [3];
   bit [1:0]    m_stable [3];
   bit [1:0]    m_req [3];
   bit          p1 [2];
   bit          p2 [2];
   bit          hist [2][256];
   int          nseen;

   int vectors = 0;
   int miscompares = 0;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         p1[c] = 1'b0;
         p2[c] = 1'b0;
      end
      nseen = 0;
      for (int i = 0; i < 3; i++) begin
         m_stable[i] = 2'b00;
         m_req[i]    = 2'b00;
      end
   endtask

   // One rising edge: the value seen after synchronisation is the raw sample from two edges ago.
   task automatic model_edge();
      bit [1:0] rawv;
      bit [1:0] clrv;
      bit       flip;
      rawv = {raw_b, raw_a};
      clrv = {clr_b, clr_a};
      for (int c = 0; c < 2; c++) begin
         hist[c][nseen % 256] = p2[c];
         p2[c] = p1[c];
         p1[c] = rawv[c];
      end
      nseen++;
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 2; c++) begin
            flip = (nseen >= int'(m_db[i]));
            if (flip) begin
               for (int j = 0; j < int'(m_db[i]); j++) begin
                  if (hist[c][(nseen - 1 - j) % 256] == m_stable[i][c]) flip = 1'b0;
               end
            end
            if (flip) m_stable[i][c] = ~m_stable[i][c];
            if (m_lt[i]) m_req[i][c] = m_stable[i][c] | (m_req[i][c] & ~clrv[c]);
            else         m_req[i][c] = m_stable[i][c];
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 2; c++) begin
            vectors++;
            assert (got_s[i][c] === m_req[i][c]) else begin
               miscompares++;
               $error("FAIL %s inst%0d ch%0d req: got %b exp %b", tag, i, c, got_s[i][c],
                      m_req[i][c]);
            end
            vectors++;
            assert (got_st[i][c] === m_stable[i][c]) else begin
               miscompares++;
               $error("FAIL %s inst%0d ch%0d stable: got %b exp %b", tag, i, c, got_st[i][c],
                      m_stable[i][c]);
            end
         end
      end
   endtask

   task automatic step(input string tag, input bit ra, input bit rb, input bit ca, input bit cb);
      raw_a = ra;
      raw_b = rb;
      clr_a = ca;
      clr_b = cb;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Reset lands between edges so the outputs must clear with no clock involved.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      check_all(tag);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      int hold_a, hold_b;
      bit ra, rb;
      m_db[0] = 4; m_lt[0] = 1'b1;
      m_db[1] = 4; m_lt[1] = 1'b0;
      m_db[2] = 1; m_lt[2] = 1'b1;
      model_reset();
      #1;
      check_all("por");
      @(posedge clk);
      #1;
      check_all("por_edge");
      #2;
      reset = 1'b1;

      for (int n = 0; n < 8; n++) step("a_rise", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 8; n++) step("a_fall_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      step("a_clr", 1'b0, 1'b0, 1'b1, 1'b0);
      step("a_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 3; n++) step("b_glitch", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) step("b_glitch_end", 1'b0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 7; n++) step("a_set", 1'b1, 1'b0, 1'b0, 1'b0);
      step("a_clr_while_set", 1'b1, 1'b0, 1'b1, 1'b0);
      step("a_clr_while_set2", 1'b1, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 7; n++) step("a_drop", 1'b0, 1'b0, 1'b0, 1'b0);
      step("a_clr_late", 1'b0, 1'b0, 1'b1, 1'b0);

      for (int n = 0; n < 7; n++) step("both_set", 1'b1, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) step("both_clr", 1'b0, 1'b0, 1'b1, 1'b1);

      for (int n = 0; n < 3; n++) step("mid_count", 1'b1, 1'b1, 1'b0, 1'b0);
      async_reset("rst_mid");
      for (int n = 0; n < 8; n++) step("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) step("hold_set", 1'b1, 1'b1, 1'b0, 1'b0);
      async_reset("rst_req");
      for (int n = 0; n < 3; n++) step("post_rst2", 1'b0, 1'b0, 1'b0, 1'b0);

      hold_a = 0;
      hold_b = 0;
      ra = 1'b0;
      rb = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (hold_a == 0) begin
            ra = ~ra;
            hold_a = $urandom_range(1, 8);
         end
         if (hold_b == 0) begin
            rb = ~rb;
            hold_b = $urandom_range(1, 8);
         end
         hold_a--;
         hold_b--;
         step("rand", ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         if (n == 700) async_reset("rand_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
